tx_serializer: RTL and testbench

Parallel-to-serial data stage of the UART transmitter, sitting directly downstream of the TX control FSM. It captures a `WIDTH`-bit word when a frame starts and shifts it out LSB-first while the FSM holds `ser_en`. It raises `ser_done` during the last data bit so the FSM can advance to Parity or Stop_bit. It also computes the frame's parity bit at capture time, which the output mux uses in the Parity state.

---
 rtl/tx_serializer.sv | 92 +++++++++
 tb/tb_tx_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tx_serializer.sv
// UART TX parallel-to-serial stage: captures a word, shifts it out LSB-first under ser_en.
// Define TX_SER_PARITY_EN to build the capture-time parity register; otherwise par_bit is 0.
module tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_valid,
    input  logic             busy,
    input  logic             ser_en,
    input  logic             PAR_TYP,
    output logic             ser_data,
    output logic             ser_done,
    output logic             par_bit
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             capture;

    assign capture = Data_valid & ~busy;

    // Capture wins over shifting; the FSM keeps busy high during Send_data anyway.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (capture) begin
            data_d  = P_DATA;
            cnt_d   = '0;
            state_d = S_SHIFT;
        end else if ((state_q == S_SHIFT) && ser_en) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign ser_data = data_q[0];
    assign ser_done = ser_en & (state_q == S_SHIFT) & (cnt_q == CNT_LAST);

`ifdef TX_SER_PARITY_EN
    logic par_q, par_d;

    // Parity is frozen at capture so it stays valid through the Parity state.
    always_comb begin
        par_d = par_q;
        if (capture) begin
            par_d = (^P_DATA) ^ PAR_TYP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_bit = par_q;
`else
    logic unused_par_typ;
    assign unused_par_typ = PAR_TYP;
    assign par_bit        = 1'b0;
`endif

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: stimulus queues expected bits, a negedge monitor checks them.
module tb_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_valid = 1'b0;
    logic       busy = 1'b0;
    logic       ser_en = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_data;
    logic       ser_done;
    logic       par_bit;

    tx_serializer #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .busy       (busy),
        .ser_en     (ser_en),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .par_bit    (par_bit)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic d;
        logic done;
        logic par;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic hold_chk = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d, input logic typ);
`ifdef TX_SER_PARITY_EN
        return (^d) ^ typ;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops one expectation for every presented bit (ser_en high or a hold/stall cycle).
    always @(negedge CLK) begin
        if (ser_en || hold_chk) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow t=%0t got=empty want=entry", $time);
            end else begin
                mon_e = q.pop_front();
                chk("ser_data", ser_data, mon_e.d);
                chk("ser_done", ser_done, mon_e.done);
                chk("par_bit", par_bit, mon_e.par);
            end
        end else begin
            chk("ser_done_when_disabled", ser_done, 1'b0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One frame: capture, Start_bit cycle, 8 Send_data cycles (optional stall), Parity/Stop.
    task automatic send_word(input logic [7:0] d, input logic typ, input int stall_at,
                             input int stall_len, input logic junk, input int idle_en);
        logic p;
        p          = exp_par(d, typ);
        P_DATA     = d;
        PAR_TYP    = typ;
        Data_valid = 1'b1;
        busy       = 1'b0;
        ser_en     = 1'b0;
        tick();
        busy       = 1'b1;
        Data_valid = junk;
        P_DATA     = junk ? 8'hFF : d;
        tick();
        for (int i = 0; i < 8; i++) begin
            ser_en = 1'b1;
            q.push_back('{d[i], (i == 7), p});
            tick();
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ser_en   = 1'b0;
                    hold_chk = 1'b1;
                    q.push_back('{d[i+1], 1'b0, p});
                    tick();
                end
                hold_chk = 1'b0;
            end
        end
        for (int n = 0; n < 2 + idle_en; n++) begin
            ser_en   = (n >= 2);
            hold_chk = 1'b1;
            q.push_back('{1'b0, 1'b0, p});
            tick();
        end
        hold_chk   = 1'b0;
        ser_en     = 1'b0;
        Data_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_ser_data", ser_data, 1'b0);
        chk("reset_ser_done", ser_done, 1'b0);
        chk("reset_par_bit", par_bit, 1'b0);
        RST = 1'b0;
        tick();

        // Mid-word asynchronous reset after 3 shifts of 8'hFF.
        P_DATA     = 8'hFF;
        PAR_TYP    = 1'b1;
        Data_valid = 1'b1;
        busy       = 1'b0;
        tick();
        Data_valid = 1'b0;
        busy       = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ser_en = 1'b1;
            q.push_back('{1'b1, 1'b0, exp_par(8'hFF, 1'b1)});
            tick();
        end
        q.push_back('{1'b0, 1'b0, 1'b0});
        #1 RST = 1'b1;
        #1;
        chk("async_rst_ser_data", ser_data, 1'b0);
        chk("async_rst_ser_done", ser_done, 1'b0);
        chk("async_rst_par_bit", par_bit, 1'b0);
        tick();
        ser_en = 1'b0;
        RST    = 1'b0;
        busy   = 1'b0;
        tick();

        send_word(8'h01, 1'b0, -1, 0, 1'b0, 0);
        send_word(8'hA5, 1'b0, -1, 0, 1'b0, 8);
        send_word(8'hA5, 1'b1, -1, 0, 1'b0, 0);
        send_word(8'h07, 1'b0, -1, 0, 1'b0, 0);
        send_word(8'h3C, 1'b0, 2, 3, 1'b0, 0);
        send_word(8'h00, 1'b1, -1, 0, 1'b1, 0);
        send_word(8'h55, 1'b1, -1, 0, 1'b0, 0);
        send_word(8'hAA, 1'b0, -1, 0, 1'b0, 0);

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
